// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes symbolic MIPS instructions and streams them into instruction memory
// Two-state loader: IDLE accepts one request, WRITE holds the word on the memory port until im_ack.
module instr_encoder #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 32,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [5:0]    funct,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  input  logic          im_ack,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  localparam logic [2:0] OP_RTYPE   = 3'd0;
  localparam logic [2:0] OP_LW      = 3'd1;
  localparam logic [2:0] OP_SW      = 3'd2;
  localparam logic [2:0] OP_BEQ     = 3'd3;
  localparam logic [2:0] OP_BMEM    = 3'd4;
  localparam logic [2:0] OP_JS      = 3'd5;
  localparam logic [2:0] OP_JMEM    = 3'd6;
  localparam logic [2:0] OP_PCTOREG = 3'd7;

  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_BMEM = 6'b010100;
  localparam logic [5:0] OPC_JS   = 6'b010011;
  localparam logic [5:0] FN_JMEM    = 6'b101101;
  localparam logic [5:0] FN_PCTOREG = 6'b010110;

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  logic [0:0]  state;
  logic [31:0] word;

  always_comb begin
    word = 32'd0;
    case (op_sel)
      OP_RTYPE:   word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      OP_LW:      word = {OPC_LW, rs, rt, imm};
      OP_SW:      word = {OPC_SW, rs, rt, imm};
      OP_BEQ:     word = {OPC_BEQ, rs, rt, imm};
      OP_BMEM:    word = {OPC_BMEM, rs, rt, imm};
      OP_JS:      word = {OPC_JS, rs, rt, imm};
      OP_JMEM:    word = {6'b000000, rs, rt, rd, 5'b00000, FN_JMEM};
      OP_PCTOREG: word = {6'b000000, rs, rt, rd, 5'b00000, FN_PCTOREG};
      default:    word = 32'd0;
    endcase
  end

  assign full     = (count == CW'(DEPTH));
  assign im_we    = (state == WRITE);
  // clear blocks acceptance combinationally so a request can never slip past a restart
  assign in_ready = (state == IDLE) && !full && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      im_addr  <= BASE;
      im_wdata <= 32'd0;
      count    <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      im_addr <= BASE;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && full) begin
            ovf <= 1'b1;
          end else if (in_valid) begin
            im_wdata <= word;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (im_ack) begin
            im_addr <= im_addr + AW'(4);
            count   <= count + CW'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a transaction-level model
// Directed vectors with literal expectations plus a per-cycle model comparison on the falling edge.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op_sel;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [5:0]    funct;
  logic          im_we;
  logic [31:0]   im_addr;
  logic [31:0]   im_wdata;
  logic          im_ack;
  logic [CW-1:0] count;
  logic          full;
  logic          ovf;

  int pass_cnt  = 0;
  int check_cnt = 0;

  instr_encoder #(.BASE_ADDR(0), .DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .funct(funct),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
    .count(count), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_encode(input logic [2:0] op, input logic [4:0] a, b, c,
                                           input logic [15:0] i, input logic [5:0] f);
    logic [31:0] opc;
    logic [31:0] fn;
    if (op == 3'd0 || op == 3'd6 || op == 3'd7) begin
      fn = (op == 3'd0) ? 32'(f) : (op == 3'd6) ? 32'd45 : 32'd22;
      return (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11) | fn;
    end
    case (op)
      3'd1:    opc = 32'd35;
      3'd2:    opc = 32'd43;
      3'd3:    opc = 32'd4;
      3'd4:    opc = 32'd20;
      default: opc = 32'd19;
    endcase
    return (opc << 26) | (32'(a) << 21) | (32'(b) << 16) | 32'(i);
  endfunction

  // Model: one pending write at most, plus address/count/overflow bookkeeping
  logic        m_busy;
  logic [31:0] m_word, m_addr;
  int          m_count;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_word <= 32'd0; m_addr <= 32'd0; m_count <= 0; m_ovf <= 1'b0;
    end else if (clear) begin
      m_busy <= 1'b0; m_addr <= 32'd0; m_count <= 0; m_ovf <= 1'b0;
    end else if (m_busy) begin
      if (im_ack) begin
        m_busy <= 1'b0; m_addr <= m_addr + 32'd4; m_count <= m_count + 1;
      end
    end else if (in_valid && m_count == DEPTH) begin
      m_ovf <= 1'b1;
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_word <= m_encode(op_sel, rs, rt, rd, imm, funct);
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", 32'(in_ready), 32'(!m_busy && m_count != DEPTH && !clear));
    chk("m_im_we", 32'(im_we), 32'(m_busy));
    chk("m_im_addr", im_addr, m_addr);
    chk("m_im_wdata", im_wdata, m_word);
    chk("m_count", 32'(count), 32'(m_count));
    chk("m_full", 32'(full), 32'(m_count == DEPTH));
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string nm, input logic [2:0] op, input logic [4:0] a, b, c,
                      input logic [15:0] i, input logic [5:0] f, input logic [31:0] exp_w,
                      input logic [31:0] exp_a, input int stall, input int exp_cnt);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({nm, "_ready_wait"}, 32'(in_ready), 32'd1);
    op_sel = op; rs = a; rt = b; rd = c; imm = i; funct = f;
    in_valid = 1'b1;
    im_ack = (stall == 0);
    step();
    in_valid = 1'b0;
    chk({nm, "_we"}, 32'(im_we), 32'd1);
    chk({nm, "_addr"}, im_addr, exp_a);
    chk({nm, "_data"}, im_wdata, exp_w);
    if (stall > 0) begin
      repeat (stall) step();
      chk({nm, "_stall_cnt"}, 32'(count), 32'(exp_cnt));
      chk({nm, "_stall_data"}, im_wdata, exp_w);
      im_ack = 1'b1;
      step();
    end else begin
      step();
    end
    im_ack = 1'b0;
    chk({nm, "_cnt"}, 32'(count), 32'(exp_cnt + 1));
    chk({nm, "_next_addr"}, im_addr, exp_a + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; im_ack = 1'b0;
    op_sel = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; funct = 6'd0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // LW with im_ack already high while idle
    im_ack = 1'b1;
    step();
    send("lw", 3'd1, 5'd2, 5'd3, 5'd0, 16'h0010, 6'd0, 32'h8C430010, 32'h0, 0, 0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr1_addr", im_addr, 32'd0);
    chk("clr1_count", 32'(count), 32'd0);

    send("jmem", 3'd6, 5'd4, 5'd0, 5'd0, 16'h0, 6'd0, 32'h0080002D, 32'h0, 0, 0);
    send("bmem", 3'd4, 5'd1, 5'd5, 5'd0, 16'hFFFC, 6'd0, 32'h5025FFFC, 32'h4, 0, 1);
    send("add_stall", 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 6'h20, 32'h00221820, 32'h8, 3, 2);
    send("pctoreg", 3'd7, 5'd0, 5'd0, 5'd31, 16'h0, 6'd0, 32'h0000F816, 32'hC, 0, 3);

    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    op_sel = 3'd2; rs = 5'd7; rt = 5'd8; imm = 16'h1234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_no_we", 32'(im_we), 32'd0);
    step();
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // clear alongside a request: clear wins, nothing is accepted
    clear = 1'b1; in_valid = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr2_count", 32'(count), 32'd0);
    chk("clr2_full", 32'(full), 32'd0);
    chk("clr2_ovf", 32'(ovf), 32'd0);
    chk("clr2_addr", im_addr, 32'd0);
    chk("clr2_we", 32'(im_we), 32'd0);

    // abort in second WRITE cycle
    op_sel = 3'd1; rs = 5'd9; rt = 5'd10; imm = 16'h0040;
    in_valid = 1'b1; im_ack = 1'b0;
    step();
    in_valid = 1'b0;
    chk("abort_we1", 32'(im_we), 32'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_we", 32'(im_we), 32'd0);
    chk("abort_count", 32'(count), 32'd0);

    send("sw", 3'd2, 5'd6, 5'd7, 5'd0, 16'h0008, 6'd0, 32'hACC70008, 32'h0, 1, 0);

    // asynchronous reset mid-write
    op_sel = 3'd5; rs = 5'd1; rt = 5'd0; imm = 16'h0100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstw_we1", 32'(im_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we", 32'(im_we), 32'd0);
    chk("rstw_addr", im_addr, 32'd0);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_data", im_wdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstw_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader for the extended MIPS core. It accepts symbolic instructions over a valid/ready handshake: an operation class plus register fields, an immediate and a funct value. It assembles the 32-bit machine word using the same opcode/funct encodings the control decoder consumes. It writes each word into instruction memory at consecutive word addresses over a stallable write port, and is used for boot-time program load and self-test.

## Interface
Parameters:
- BASE_ADDR, 0: byte address of the first word written after reset or clear.
- DEPTH, 256: number of words the block may write before it reports full.
- AW, 32: width of im_addr.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: address back to BASE_ADDR, count and ovf to 0.
- in_valid  in  1  request carries an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- op_sel  in  3  operation class: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 BMEM, 5 JS, 6 JMEM, 7 PCTOREG.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate; used by I-type classes.
- funct  in  6  funct field; used only by RTYPE.
- im_we  out  1  write request to instruction memory.
- im_addr  out  AW  byte address of the word being written.
- im_wdata  out  32  encoded word.
- im_ack  in  1  memory accepted the write this cycle.
- count  out  clog2(DEPTH+1)  words written since reset or clear.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky flag: in_valid was seen while full.

## Operation
- Encoding:
  - I-type word = {opcode, rs, rt, imm}. Opcodes: LW 100011, SW 101011, BEQ 000100, BMEM 010100, JS 010011.
  - R-type word = {000000, rs, rt, rd, 00000, f}.
  - f is: funct for RTYPE, 101101 for JMEM, 010110 for PCTOREG.
  - Every op_sel value is legal; there is no decode error.
- FSM state IDLE:
  - in_ready = !full.
  - in_valid && in_ready latches the encoded word into an internal register and moves to WRITE.
  - in_valid && full sets ovf; no state change.
- FSM state WRITE:
  - im_we = 1; im_addr and im_wdata come from registers and hold stable until im_ack.
  - in_ready = 0.
  - im_ack: im_addr += 4, count += 1, return to IDLE.
- Address arithmetic is modulo 2^AW. count never exceeds DEPTH.
- clear:
  - Has priority over everything else in any state.
  - In WRITE it aborts the write: im_we drops the next cycle, the word is discarded and the state returns to IDLE.
  - clear together with im_ack: the clear wins and count ends at 0.
  - clear together with in_valid: the request is not accepted; in_ready is 0 in any cycle where clear = 1.
- Reset values: state IDLE, in_ready 1, im_we 0, im_addr BASE_ADDR, im_wdata 0, count 0, full 0, ovf 0.
- rst_n asserted mid-write drops im_we asynchronously; no partial state survives.

## Timing
- Acceptance at edge N drives im_we = 1 with valid addr/data from N+1.
- With im_ack in the first WRITE cycle, in_ready is 1 again after the next edge. Peak throughput is 1 word per 2 cycles.
- im_ack held low for k cycles extends WRITE by k cycles; outputs stay stable throughout.
- im_ack while im_we = 0 is ignored.
- full rises on the same edge where count reaches DEPTH. in_ready is 0 from that cycle on.
- ovf updates one edge after the offending in_valid and stays set until clear or reset.

## Test plan
- Reset: hold rst_n = 0, then release -> in_ready = 1, im_we = 0, im_addr = BASE_ADDR, count = 0, full = 0, ovf = 0.
- LW: op_sel = 1, rs = 2, rt = 3, imm = 0x0010; im_ack tied high -> im_wdata = 0x8C430010 at im_addr = 0x0; then count = 1 and im_addr = 0x4.
- JMEM then BMEM back to back:
  - JMEM: rs = 4, rt = 0, rd = 0 -> im_wdata = 0x0080002D.
  - BMEM: rs = 1, rt = 5, imm = 0xFFFC -> im_wdata = 0x5025FFFC at address 0x4.
  - in_ready pattern is 1, 0, 1, 0.
- Memory stall: hold im_ack low for 3 cycles -> im_we, im_addr and im_wdata stay stable for 4 cycles, and count increments only after im_ack.
- Full with DEPTH = 4: four writes -> full = 1 and in_ready = 0; a fifth in_valid -> ovf = 1, no im_we. Then clear -> count = 0, full = 0, ovf = 0, im_addr = BASE_ADDR.
- Abort: clear in the second WRITE cycle with im_ack low -> im_we = 0 the next cycle, count = 0. Separately, rst_n pulsed mid-WRITE -> im_we drops immediately and all outputs return to reset values.
